// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the memory-mapped UART transmitter: store strobe,
// address and store data in, address-hit and register read data back.
interface mmio_uart_tx_if;
  logic        write_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        hit;
  logic [31:0] read_data;

  modport master (
    output write_en, addr, write_data,
    input  hit, read_data
  );

  modport slave (
    input  write_en, addr, write_data,
    output hit, read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores fill a FIFO that a frame FSM serializes on tx.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [7:0]          shift;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  logic                full, empty, busy;
  logic                push, status_wr, accept, pop, baud_last;
  logic [7:0]          pop_data;
  logic                unused_bits;

  // Bus decode: one 8-byte window, addr[2] selects TXDATA/STATUS.
  assign bus.hit   = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign push      = bus.write_en && bus.hit && !bus.addr[2];
  assign status_wr = bus.write_en && bus.hit &&  bus.addr[2];

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign pop_data  = mem[rd_ptr];

  // A pop only happens on a byte already stored before this edge, so an
  // empty-FIFO push is never consumed in the same cycle.
  assign pop    = !empty && ((state == IDLE) || (state == STOP && baud_last));
  assign accept = push && (!full || pop);

  assign unused_bits = ^{bus.addr[1:0], bus.write_data[31:8]};

  always_comb begin
    // NOTE: default assignment first so no path through this block leaves
    // read_data unassigned, which would otherwise infer a latch.
    bus.read_data = '0;
    if (bus.hit && bus.addr[2])
      bus.read_data = {16'h0, 8'(count), 3'b000, PARITY_EN, overflow, busy, empty, full};
  end

  // NOTE: the FIFO storage has no reset; count and pointers define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= bus.write_data[7:0];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop)
        count <= count + CNT_W'(1);
      else if (!accept && pop)
        count <= count - CNT_W'(1);
      if (push && !accept)
        overflow <= 1'b1;
      else if (status_wr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: tx <= 1'b1;
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase

      // Loading a byte overrides the case above; from STOP this chains the
      // next start bit straight after the last stop cycle.
      if (pop) begin
        shift    <= pop_data;
        baud_cnt <= '0;
        bit_idx  <= '0;
        tx       <= 1'b0;
        state    <= START;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^pop_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8; honours UART_TX_PARITY_EN.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int          FRAME   = (10 + PAR) * CPB;
  localparam logic [31:0] ST_PAR  = (PAR != 0) ? 32'h10 : 32'h0;
  localparam logic [31:0] ST_IDLE = 32'h2 | ST_PAR;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected line level k cycles after the store edge.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    if (k < 1) return 1'b1;
    idx = (k - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR != 0 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.write_en   = 1'b1;
    bus.addr       = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.addr     = BASE + 32'd4;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    bus.addr = BASE + 32'd4;
    #1;
    check(tag, bus.read_data, exp);
  endtask

  task automatic send_and_check(input logic [7:0] b);
    store(BASE, {24'h0, b});
    for (int k = 0; k <= FRAME + 1; k++) begin
      @(negedge clk);
      check($sformatf("tx byte %02h k=%0d", b, k), {31'h0, tx}, {31'h0, exp_tx(b, k)});
      if (k == 1)         check("busy first start cycle", {31'h0, bus.read_data[2]}, 32'h1);
      if (k == FRAME)     check("busy last stop cycle",   {31'h0, bus.read_data[2]}, 32'h1);
      if (k == FRAME + 1) check("busy after frame",       {31'h0, bus.read_data[2]}, 32'h0);
    end
  endtask

  // Mid-bit sampling receiver; start_cyc is the first cycle the start bit is seen.
  task automatic receive_frame(output logic [7:0] b, output int start_cyc);
    int n;
    n = 0;
    b = '0;
    start_cyc = -1;
    @(negedge clk);
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx start bit seen", {31'h0, tx}, 32'h0);
    if (tx !== 1'b0) return;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? (CPB + CPB / 2) : CPB) @(negedge clk);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    check("rx parity bit", {31'h0, tx}, {31'h0, ^b});
`endif
    repeat (CPB) @(negedge clk);
    check("rx stop bit", {31'h0, tx}, 32'h1);
  endtask

  task automatic wait_idle(output int idle_cyc);
    int n;
    n = 0;
    bus.addr = BASE + 32'd4;
    #1;
    while (bus.read_data[2] !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("fsm returns idle", {31'h0, bus.read_data[2]}, 32'h0);
    idle_cyc = cyc;
  endtask

  initial begin
    logic [7:0] rb;
    int         s1, s2, idle_c, zeros;

    bus.write_en   = 1'b0;
    bus.addr       = BASE + 32'd4;
    bus.write_data = '0;

    // Reset and register decode.
    repeat (3) @(negedge clk);
    check("tx during reset", {31'h0, tx}, 32'h1);
    read_status("status during reset", ST_IDLE);
    reset = 1'b1;
    @(negedge clk);
    check("tx after reset", {31'h0, tx}, 32'h1);
    read_status("status after reset", ST_IDLE);
    bus.addr = BASE + 32'd8;
    #1;
    check("hit outside window", {31'h0, bus.hit}, 32'h0);
    check("read_data outside window", bus.read_data, 32'h0);
    bus.addr = BASE;
    #1;
    check("hit on txdata", {31'h0, bus.hit}, 32'h1);
    check("txdata reads zero", bus.read_data, 32'h0);
    bus.addr = BASE + 32'd7;
    #1;
    check("status ignores addr[1:0]", bus.read_data, ST_IDLE);

    // Single frames, cycle exact.
    send_and_check(8'h55);
    send_and_check(8'h07);
    read_status("status idle after frames", ST_IDLE);

    // Overflow: ten back-to-back stores, nine land.
    fork
      begin
        @(negedge clk);
        bus.write_en = 1'b1;
        bus.addr     = BASE;
        for (int i = 0; i < 10; i++) begin
          bus.write_data = 32'hA0 + i;
          @(negedge clk);
        end
        bus.write_en = 1'b0;
        read_status("status full with overflow", 32'h0000_080D | ST_PAR);
        store(BASE + 32'd4, 32'hFFFF_FFFF);
        read_status("overflow cleared", 32'h0000_0805 | ST_PAR);
      end
      begin
        for (int j = 0; j < 9; j++) begin
          logic [7:0] ob;
          int         os;
          receive_frame(ob, os);
          check($sformatf("fifo order byte %0d", j), {24'h0, ob}, 32'hA0 + j);
        end
      end
    join
    wait_idle(idle_c);
    read_status("status after drain", ST_IDLE);

    // Back-to-back frames without an idle gap.
    fork
      begin
        store(BASE, 32'h01);
        store(BASE, 32'h80);
      end
      begin
        receive_frame(rb, s1);
        check("b2b first byte", {24'h0, rb}, 32'h01);
        receive_frame(rb, s2);
        check("b2b second byte", {24'h0, rb}, 32'h80);
      end
    join
    check("b2b start spacing", s2 - s1, FRAME);
    wait_idle(idle_c);
    check("b2b total activity", idle_c - s1, 2 * FRAME);
    read_status("status after b2b", ST_IDLE);

    // Reset in the middle of a frame.
    store(BASE, 32'h00);
    repeat (10) @(negedge clk);
    check("mid-frame data low", {31'h0, tx}, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("async reset forces tx high", {31'h0, tx}, 32'h1);
    read_status("status in mid-frame reset", ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("no residual frame after reset", zeros, 0);
    read_status("status after mid-frame reset", ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
